// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port data-memory arbiter: port ids, latency
// bound and the in-flight read tag carried alongside the memory pipeline.
package mem_arb_pkg;

  localparam logic PORT_LS     = 1'b0;
  localparam logic PORT_AUX    = 1'b1;
  localparam int   MEM_LAT_MAX = 4;

  typedef struct packed {
    logic valid;
    logic port;
  } tag_t;

  function automatic logic [14:0] word_addr(input logic [15:0] byte_addr);
    return byte_addr[15:1];
  endfunction

endpackage

// File: rtl/arb_tag_pipe.sv
// Fixed-depth shift register of read tags; the head entry lines up with the
// memory's read data and says which requester that data belongs to.
module arb_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  tag_t in_tag,
  output tag_t head
);

  tag_t stage [DEPTH];

  // NOTE: this is a pipeline of control flags, not a data array, so every
  // stage is reset; that is what drops in-flight reads on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments let each stage take its neighbour's old value.
      stage[0] <= in_tag;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign head = stage[DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the load/store path and an auxiliary requester onto one memory
// port, and steers each read response back to the port that issued it.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter bit RR      = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid0,
  input  logic        req_wen0,
  input  logic [15:0] req_addr0,
  input  logic [15:0] req_wdata0,
  output logic        req_ready0,
  output logic        rsp_valid0,
  input  logic        req_valid1,
  input  logic        req_wen1,
  input  logic [15:0] req_addr1,
  input  logic [15:0] req_wdata1,
  output logic        req_ready1,
  output logic        rsp_valid1,
  output logic [15:0] rsp_data,
  output logic [14:0] m_raddr,
  input  logic [15:0] m_rdata,
  output logic        m_wen,
  output logic [14:0] m_waddr,
  output logic [15:0] m_wdata,
  output logic [15:0] conflict_cnt
);

  logic last_grant;
  logic gnt0;
  logic gnt1;
  tag_t issue_tag;
  tag_t head;
  logic unused_addr_lsb;

  assign unused_addr_lsb = req_addr0[0] ^ req_addr1[0];

  // Grants are gated by rst_n so the port looks idle while reset is held.
  always_comb begin
    // NOTE: defaults first, so no branch leaves a grant unassigned (no latch).
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n) begin
      if (req_valid0 && req_valid1) begin
        if (RR && last_grant == PORT_LS) gnt1 = 1'b1;
        else                             gnt0 = 1'b1;
      end else begin
        gnt0 = req_valid0;
        gnt1 = req_valid1;
      end
    end
  end

  assign req_ready0 = gnt0;
  assign req_ready1 = gnt1;

  always_comb begin
    m_wen   = 1'b0;
    m_waddr = '0;
    m_wdata = '0;
    if (gnt0) begin
      m_wen   = req_wen0;
      m_waddr = word_addr(req_addr0);
      m_wdata = req_wdata0;
    end else if (gnt1) begin
      m_wen   = req_wen1;
      m_waddr = word_addr(req_addr1);
      m_wdata = req_wdata1;
    end
  end

  assign m_raddr = m_waddr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant   <= PORT_AUX;
      conflict_cnt <= '0;
    end else begin
      if (gnt0)      last_grant <= PORT_LS;
      else if (gnt1) last_grant <= PORT_AUX;
      if (req_valid0 && req_valid1) conflict_cnt <= conflict_cnt + 16'd1;
    end
  end

  // Only reads are tagged; writes never produce a response.
  always_comb begin
    issue_tag.valid = (gnt0 && !req_wen0) || (gnt1 && !req_wen1);
    issue_tag.port  = gnt1;
  end

  arb_tag_pipe #(.DEPTH(MEM_LAT)) u_tag_pipe (
    .clk    (clk),
    .rst_n  (rst_n),
    .in_tag (issue_tag),
    .head   (head)
  );

  assign rsp_valid0 = head.valid && (head.port == PORT_LS);
  assign rsp_valid1 = head.valid && (head.port == PORT_AUX);
  assign rsp_data   = head.valid ? m_rdata : 16'h0000;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single data-side memory port (read address/data plus write enable/address/data) between two requesters.
  - Port 0: load/store path.
  - Port 1: secondary requester, e.g. debug loader or second pipeline stage.
- Valid/ready request handshake, one grant per cycle, round-robin or fixed priority.
- Tracks in-flight reads and routes each read response back to the requester that issued it, after a fixed memory latency.
- Sits between the CPU datapath and the `mem` instance's second port.

Parameters:
- MEM_LAT, 1, read latency of the memory in cycles (legal 1..4); `m_rdata` is valid MEM_LAT cycles after the address is presented.
- RR, 1, 1 = round-robin arbitration; 0 = fixed priority, port 0 always wins.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid0  input  1  port 0 request present.
- req_wen0  input  1  port 0: 1 = write, 0 = read.
- req_addr0  input  16  port 0 byte address; bit 0 ignored.
- req_wdata0  input  16  port 0 write data.
- req_ready0  output  1  port 0 request accepted this cycle.
- rsp_valid0  output  1  read data for port 0 is on rsp_data.
- req_valid1, req_wen1, req_addr1, req_wdata1, req_ready1, rsp_valid1  same as port 0, for port 1.
- rsp_data  output  16  read response data, shared by both ports.
- m_raddr  output  15  memory read word address.
- m_rdata  input  16  memory read data.
- m_wen  output  1  memory write enable.
- m_waddr  output  15  memory write word address.
- m_wdata  output  16  memory write data.
- conflict_cnt  output  16  count of cycles where both req_valid inputs were high; wraps at 0xFFFF -> 0.

Behaviour:
- Reset (rst_n low, asynchronous):
  - last_grant = 1, so port 0 wins the first conflict.
  - Tag pipeline cleared; conflict_cnt = 0.
  - Outputs forced: req_ready* = 0, rsp_valid* = 0, m_wen = 0, addresses/wdata/rsp_data = 0.
  - In-flight reads are dropped: no rsp_valid for them after reset release.
- Grant logic (combinational, same cycle):
  - Only one valid: that port is granted.
  - Both valid, RR = 1: the port != last_grant is granted.
  - Both valid, RR = 0: port 0 is granted.
  - req_ready_g = 1 only for the granted port g; at most one req_ready is high per cycle.
  - A request is accepted on a posedge where valid && ready. Requesters hold valid/wen/addr/wdata stable until accepted.
- last_grant updates to the granted port on every accepted request. It does not change on idle cycles.
- Memory drive in the grant cycle:
  - m_raddr = m_waddr = granted addr[15:1]; m_wdata = granted wdata.
  - m_wen = granted wen.
  - With no grant: m_wen = 0 and all addresses/data = 0.
- Write responses: writes generate no response.
- Read responses:
  - Read accepted in cycle N -> rsp_valid_g = 1 for exactly cycle N+MEM_LAT, with rsp_data = m_rdata in that cycle.
  - Tag pipeline: MEM_LAT stages of {valid, port id}, shifted every cycle.
  - Back-to-back reads from either port are allowed every cycle; responses return in acceptance order, one per cycle.
  - No rsp_valid asserted: rsp_data = 0.
- Ordering: the arbiter never reorders requests. A write accepted in cycle N followed by a read of the same address accepted in N+1 returns the new data, since memory writes take effect at the posedge.
- conflict_cnt increments on each posedge where req_valid0 && req_valid1 (regardless of grant), wrapping.
- Fairness: with RR = 1 and both ports continuously valid, grants strictly alternate 0,1,0,1..., so worst-case wait is 1 cycle.

Decomposition:
- Shared package `mem_arb_pkg` holds:
  - Constants PORT_LS = 0, PORT_AUX = 1, MEM_LAT_MAX = 4.
  - Typedef of the tag entry {valid, port}.
- One sub-module: `arb_tag_pipe`, a MEM_LAT-deep shift register of tag entries with async active-low clear. Outputs the head entry, which drives rsp_valid0/1.

Test Plan:
- Reset, idle 5 cycles -> m_wen = 0, req_ready* = 0, rsp_valid* = 0, conflict_cnt = 0.
- Port 0 writes 0x1234 to addr 0x0010, then reads 0x0010 next cycle (MEM_LAT = 1) -> m_waddr = 0x0008 with m_wen = 1; rsp_valid0 = 1 one cycle after the read is accepted, rsp_data = 0x1234; rsp_valid1 stays 0.
- Both ports hold reads for 6 cycles (RR = 1) -> grants 0,1,0,1,0,1; responses alternate ports one cycle later; conflict_cnt = 6.
- Same stimulus with RR = 0 -> port 0 granted all 6 cycles, req_ready1 stays 0; conflict_cnt = 6.
- MEM_LAT = 3, port 1 reads addr 0x0020 then rst_n pulsed low 1 cycle later -> no rsp_valid1 ever asserts; after release the first conflict grants port 0.
- Force conflict_cnt to 0xFFFF, one more conflict cycle -> conflict_cnt = 0x0000.
